ps2_kbd_host: RTL and testbench
===============================

# ps2_kbd_host

PS/2 keyboard host controller between the board PS/2 keyboard pins and the system-management register logic. It deserialises device-to-host frames into an RX FIFO, tracks the BAT-OK code, and sends 1- or 2-byte host-to-device commands with inhibit/request-to-send signalling. It reports the keyboard's ACK/ERR reply in a status register. Time bases use the 1 µs strobe `ck1us` from the companion `pulser` block, which emits one 1-cycle pulse per microsecond of `clk6x`.

## Interface
- RXBUF_DEPTH_BITS, 3, log2 of RX FIFO depth (default depth 8)
- clk6x  in  1  system clock (48 MHz)
- resetn  in  1  synchronous, active-low reset
- ck1us  in  1  1-cycle pulse every 1 µs
- kbd_rdata_o  out  8  FIFO head byte; 0x00 when empty
- kbd_rvalid_o  out  1  FIFO not empty
- kbd_rcount_o  out  RXBUF_DEPTH_BITS+1  bytes in FIFO
- kbd_rdeq_i  in  1  pop FIFO head (1-cycle pulse)
- kbd_stat_o  out  8  0x00 idle, 0x01 pending, 0xFA ACK, 0xFE error
- kbd_bat_ok_o  out  1  sticky; set when 0xAA is received
- kbd_wcmddata_i  in  8  command/data byte
- kbd_enq_cmd1_i  in  1  start a 1-byte command
- kbd_enq_cmd2_i  in  1  load a 2-byte command (two pulses)
- PS2K_CLK, PS2K_DATA  in  1  pin levels
- PS2K_CLKDR, PS2K_DATADR  out  1  1 = drive pin low, 0 = release (Hi-Z, pulled up)

## Operation
Input conditioning:
- PS2K_CLK and PS2K_DATA pass through 2-FF synchronisers.
- A CLK falling edge counts only after the synchronised CLK has been low for 8 consecutive clk6x cycles.

RX (device to host, when the TX engine is idle):
- Frame: start 0, 8 data bits LSB first, odd parity, stop 1. Each bit is sampled at the CLK falling edge.
- If more than 2000 µs pass between edges mid-frame, the frame is discarded and the receiver resets.
- On a bad start, parity or stop bit, the byte is discarded.
- A good byte of 0xAA sets kbd_bat_ok.
- A good byte of 0xFA or 0xFE while kbd_stat=0x01 is routed to the reply logic.
- Every other good byte, including 0xAA, is pushed into the FIFO. When the FIFO is full the byte is dropped.

FIFO:
- Circular buffer of depth 2^RXBUF_DEPTH_BITS.
- Push and pop in the same cycle leave the count unchanged.
- Pop when empty is ignored.
- kbd_rdata_o is combinational from the head entry.

TX command loading:
- cmd1 pulse: latch the byte and start sending it.
- First cmd2 pulse: latch the command byte and wait.
- Second cmd2 pulse: latch the data byte and start sending the command byte.
- Enqueue pulses are ignored while the TX engine is in INHIBIT/SHIFT/ACK. They are accepted while waiting for a reply; this restarts the sequence.

TX states:
- IDLE
- INHIBIT: CLKDR=1 for 100 µs.
- RTS: DATADR=1, then CLKDR=0.
- SHIFT:
  - Falling edges 1..8 put data bits 0..7 on DATADR (DATADR = ~bit).
  - Falling edge 9 puts the odd parity bit.
  - Falling edge 10 releases DATADR (stop bit).
- ACK: falling edge 11 samples DATA. If DATA=0, go to REPLY; otherwise set stat=0xFE and return to IDLE.
- Any gap over 15000 µs in SHIFT/ACK: release both pins, stat=0xFE, IDLE.

Reply handling:
- kbd_stat is set to 0x01 on entering INHIBIT.
- Reply 0xFA after the first byte of a 2-byte command: send the data byte (INHIBIT again).
- Reply 0xFA after the last byte: stat=0xFA.
- Reply 0xFE: abort and set stat=0xFE.
- No reply within 20000 µs: stat=0xFE.

## Timing
- Reset values:
  - all outputs 0, kbd_rdata_o=0x00, kbd_stat=0x00
  - FIFO empty, TX in IDLE
  - any transfer in progress is aborted and both pins are released
- RX byte visible (rvalid=1) at most 12 clk6x cycles after the 11th CLK falling edge at the pin.
- kbd_rdeq_i sampled at a clk6x edge: the head, count and rvalid update on that edge.
- PS2K_CLKDR asserts at most 2 cycles after a start enqueue. It releases 100 µs (±1 µs) later; DATADR=1 is asserted no later than the same cycle.
- Each DATADR update follows its CLK falling edge within 12 cycles.

## Test plan
- After reset, 200 cycles idle -> rdata=0x00, rvalid=0, rcount=0, stat=0x00, pins released.
- Device sends 0xC7, then 0x7C (33 µs half-period) -> rdata=0xC7, rvalid=1, rcount=2. Pop -> rdata=0x7C, rvalid=1. Pop -> rvalid=0, rdata=0x00.
- cmd1 0xA5 -> CLKDR low for 100 µs, then start bit. The device clocks out bits 1,0,1,0,0,1,0,1, parity 1, stop released, ACK 0 -> stat stays 0x01 until the 20 ms timeout, then 0xFE.
- cmd2 0x55 then cmd2 0xAA -> 0x55 is sent first. Device replies 0xFA -> 0xAA is sent. Device replies 0xFA -> stat=0xFA, FIFO empty.
- Frame with bad parity -> discarded, rcount unchanged. Device sends 0xAA -> kbd_bat_ok=1 and 0xAA is in the FIFO.
- 9 bytes received with no pops -> rcount=8, the 9th byte is dropped, head = first byte.

Source files
------------

// File: rtl/ps2_kbd_host.sv
// PS/2 keyboard host: pin conditioning, RX deserialiser with FIFO, and a
// host-to-device command engine with ACK/ERR reply tracking.
module ps2_kbd_host #(
  parameter int unsigned RXBUF_DEPTH_BITS = 3
) (
  input  logic                        clk6x,
  input  logic                        resetn,
  input  logic                        ck1us,
  output logic [7:0]                  kbd_rdata_o,
  output logic                        kbd_rvalid_o,
  output logic [RXBUF_DEPTH_BITS:0]   kbd_rcount_o,
  input  logic                        kbd_rdeq_i,
  output logic [7:0]                  kbd_stat_o,
  output logic                        kbd_bat_ok_o,
  input  logic [7:0]                  kbd_wcmddata_i,
  input  logic                        kbd_enq_cmd1_i,
  input  logic                        kbd_enq_cmd2_i,
  input  logic                        PS2K_CLK,
  input  logic                        PS2K_DATA,
  output logic                        PS2K_CLKDR,
  output logic                        PS2K_DATADR
);

  localparam int unsigned DEPTH        = 1 << RXBUF_DEPTH_BITS;
  localparam int unsigned CNT_W        = RXBUF_DEPTH_BITS + 1;
  localparam int unsigned FILT_LOW     = 8;
  localparam int unsigned RX_TMO_US    = 2000;
  localparam int unsigned INH_US       = 100;
  localparam int unsigned TX_TMO_US    = 15000;
  localparam int unsigned REPLY_TMO_US = 20000;

  localparam logic [7:0] ST_IDLE = 8'h00;
  localparam logic [7:0] ST_PEND = 8'h01;
  localparam logic [7:0] ST_ACK  = 8'hFA;
  localparam logic [7:0] ST_ERR  = 8'hFE;
  localparam logic [7:0] BAT_OK  = 8'hAA;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_INHIBIT,
    TX_RTS,
    TX_SHIFT,
    TX_ACK,
    TX_REPLY
  } tx_st_t;

  // Pin conditioning
  logic       r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
  logic [3:0] r_low_cnt;
  logic       w_fall;

  // RX
  logic [3:0]  r_rx_cnt;
  logic [9:0]  r_rx_sh;
  logic [10:0] r_rx_tmo;
  logic        r_rx_push;
  logic        r_rx_reply;
  logic [7:0]  r_rx_byte;
  logic        r_bat_ok;
  logic        w_rx_en;
  logic [7:0]  w_rx_data;
  logic        w_rx_good;
  logic        w_rx_is_reply;

  // FIFO
  logic [7:0]                  r_mem [DEPTH];
  logic [RXBUF_DEPTH_BITS-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0]            r_count;
  logic                        w_push, w_pop;

  // TX
  tx_st_t      r_tx_st;
  logic        r_clkdr, r_datadr;
  logic [7:0]  r_stat;
  logic [14:0] r_tx_tmr;
  logic [3:0]  r_tx_bitn;
  logic [7:0]  r_tx_byte, r_tx_cmd, r_tx_data;
  logic        r_two, r_half;
  logic        w_enq_ok, w_start1, w_start2, w_load2, w_resend, w_start;
  logic        w_tx_par;

  // A falling edge is the 8th consecutive low cycle of the synchronised clock
  assign w_fall = !r_clk_s2 && (r_low_cnt == 4'(FILT_LOW - 1));

  // 2-FF synchronisers and CLK low-time filter
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      r_clk_s1  <= 1'b1;
      r_clk_s2  <= 1'b1;
      r_dat_s1  <= 1'b1;
      r_dat_s2  <= 1'b1;
      r_low_cnt <= 4'd0;
    end else begin
      r_clk_s1 <= PS2K_CLK;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= PS2K_DATA;
      r_dat_s2 <= r_dat_s1;
      if (r_clk_s2)
        r_low_cnt <= 4'd0;
      else if (r_low_cnt != 4'(FILT_LOW))
        r_low_cnt <= r_low_cnt + 4'd1;
    end
  end

  // Receiver listens only while the TX engine is idle or awaiting a reply
  assign w_rx_en       = (r_tx_st == TX_IDLE) || (r_tx_st == TX_REPLY);
  assign w_rx_data     = r_rx_sh[8:1];
  assign w_rx_good     = !r_rx_sh[0] && r_dat_s2 && (^r_rx_sh[9:1]);
  assign w_rx_is_reply = ((w_rx_data == ST_ACK) || (w_rx_data == ST_ERR)) &&
                         (r_stat == ST_PEND);

  // RX frame deserialiser with inter-edge timeout and byte routing
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      r_rx_cnt   <= 4'd0;
      r_rx_sh    <= 10'd0;
      r_rx_tmo   <= 11'd0;
      r_rx_push  <= 1'b0;
      r_rx_reply <= 1'b0;
      r_rx_byte  <= 8'h00;
      r_bat_ok   <= 1'b0;
    end else begin
      r_rx_push  <= 1'b0;
      r_rx_reply <= 1'b0;
      if (!w_rx_en) begin
        r_rx_cnt <= 4'd0;
        r_rx_tmo <= 11'd0;
      end else if (w_fall) begin
        r_rx_tmo <= 11'd0;
        if (r_rx_cnt == 4'd10) begin
          r_rx_cnt <= 4'd0;
          if (w_rx_good) begin
            r_rx_byte <= w_rx_data;
            if (w_rx_data == BAT_OK)
              r_bat_ok <= 1'b1;
            if (w_rx_is_reply)
              r_rx_reply <= 1'b1;
            else
              r_rx_push <= 1'b1;
          end
        end else begin
          r_rx_cnt <= r_rx_cnt + 4'd1;
          r_rx_sh  <= {r_dat_s2, r_rx_sh[9:1]};
        end
      end else if ((r_rx_cnt != 4'd0) && ck1us) begin
        if (r_rx_tmo == 11'(RX_TMO_US)) begin
          r_rx_cnt <= 4'd0;
          r_rx_tmo <= 11'd0;
        end else begin
          r_rx_tmo <= r_rx_tmo + 11'd1;
        end
      end
    end
  end

  assign w_push = r_rx_push && (r_count != CNT_W'(DEPTH));
  assign w_pop  = kbd_rdeq_i && (r_count != '0);

  // FIFO storage; contents beyond the count are never observed
  always_ff @(posedge clk6x) begin
    if (w_push)
      r_mem[r_wptr] <= r_rx_byte;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push)
        r_wptr <= r_wptr + RXBUF_DEPTH_BITS'(1);
      if (w_pop)
        r_rptr <= r_rptr + RXBUF_DEPTH_BITS'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_enq_ok = (r_tx_st == TX_IDLE) || (r_tx_st == TX_REPLY);
  assign w_start1 = w_enq_ok && kbd_enq_cmd1_i;
  assign w_start2 = w_enq_ok && !kbd_enq_cmd1_i && kbd_enq_cmd2_i && r_half;
  assign w_load2  = w_enq_ok && !kbd_enq_cmd1_i && kbd_enq_cmd2_i && !r_half;
  assign w_resend = (r_tx_st == TX_REPLY) && r_rx_reply && (r_rx_byte == ST_ACK) && r_two;
  assign w_start  = w_start1 || w_start2 || w_resend;
  assign w_tx_par = ~^r_tx_byte;

  // TX engine: inhibit, request-to-send, bit shifting, device ACK and reply wait
  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      r_tx_st   <= TX_IDLE;
      r_clkdr   <= 1'b0;
      r_datadr  <= 1'b0;
      r_stat    <= ST_IDLE;
      r_tx_tmr  <= 15'd0;
      r_tx_bitn <= 4'd0;
      r_tx_byte <= 8'h00;
      r_tx_cmd  <= 8'h00;
      r_tx_data <= 8'h00;
      r_two     <= 1'b0;
      r_half    <= 1'b0;
    end else begin
      if (w_start) begin
        r_tx_st   <= TX_INHIBIT;
        r_clkdr   <= 1'b1;
        r_datadr  <= 1'b0;
        r_tx_tmr  <= 15'd0;
        r_tx_bitn <= 4'd0;
        r_stat    <= ST_PEND;
        r_two     <= w_start2;
        if (w_start1) begin
          r_tx_byte <= kbd_wcmddata_i;
        end else if (w_start2) begin
          r_tx_byte <= r_tx_cmd;
          r_tx_data <= kbd_wcmddata_i;
        end else begin
          r_tx_byte <= r_tx_data;
        end
      end else begin
        case (r_tx_st)
          TX_INHIBIT: begin
            if (ck1us) begin
              if (r_tx_tmr == 15'(INH_US - 1)) begin
                r_datadr <= 1'b1;
                r_tx_st  <= TX_RTS;
              end else begin
                r_tx_tmr <= r_tx_tmr + 15'd1;
              end
            end
          end
          TX_RTS: begin
            r_clkdr   <= 1'b0;
            r_tx_tmr  <= 15'd0;
            r_tx_bitn <= 4'd0;
            r_tx_st   <= TX_SHIFT;
          end
          TX_SHIFT: begin
            if (w_fall) begin
              r_tx_tmr  <= 15'd0;
              r_tx_bitn <= r_tx_bitn + 4'd1;
              if (r_tx_bitn < 4'd8) begin
                r_datadr <= ~r_tx_byte[r_tx_bitn[2:0]];
              end else if (r_tx_bitn == 4'd8) begin
                r_datadr <= ~w_tx_par;
              end else begin
                r_datadr <= 1'b0;
                r_tx_st  <= TX_ACK;
              end
            end else if (ck1us) begin
              if (r_tx_tmr == 15'(TX_TMO_US)) begin
                r_clkdr  <= 1'b0;
                r_datadr <= 1'b0;
                r_stat   <= ST_ERR;
                r_two    <= 1'b0;
                r_tx_st  <= TX_IDLE;
              end else begin
                r_tx_tmr <= r_tx_tmr + 15'd1;
              end
            end
          end
          TX_ACK: begin
            if (w_fall) begin
              r_tx_tmr <= 15'd0;
              if (!r_dat_s2) begin
                r_tx_st <= TX_REPLY;
              end else begin
                r_stat  <= ST_ERR;
                r_two   <= 1'b0;
                r_tx_st <= TX_IDLE;
              end
            end else if (ck1us) begin
              if (r_tx_tmr == 15'(TX_TMO_US)) begin
                r_clkdr  <= 1'b0;
                r_datadr <= 1'b0;
                r_stat   <= ST_ERR;
                r_two    <= 1'b0;
                r_tx_st  <= TX_IDLE;
              end else begin
                r_tx_tmr <= r_tx_tmr + 15'd1;
              end
            end
          end
          TX_REPLY: begin
            if (r_rx_reply) begin
              r_stat  <= (r_rx_byte == ST_ERR) ? ST_ERR : ST_ACK;
              r_two   <= 1'b0;
              r_tx_st <= TX_IDLE;
            end else if (ck1us) begin
              if (r_tx_tmr == 15'(REPLY_TMO_US - 1)) begin
                r_stat  <= ST_ERR;
                r_two   <= 1'b0;
                r_tx_st <= TX_IDLE;
              end else begin
                r_tx_tmr <= r_tx_tmr + 15'd1;
              end
            end
          end
          default: ;
        endcase
      end
      if (w_load2) begin
        r_tx_cmd <= kbd_wcmddata_i;
        r_half   <= 1'b1;
      end else if (w_start) begin
        r_half <= 1'b0;
      end
    end
  end

  assign kbd_rdata_o  = (r_count != '0) ? r_mem[r_rptr] : 8'h00;
  assign kbd_rvalid_o = (r_count != '0);
  assign kbd_rcount_o = r_count;
  assign kbd_stat_o   = r_stat;
  assign kbd_bat_ok_o = r_bat_ok;
  assign PS2K_CLKDR   = r_clkdr;
  assign PS2K_DATADR  = r_datadr;

endmodule

// File: tb/tb_ps2_kbd_host.sv
// Bench for ps2_kbd_host: a PS/2 device model on open-drain pins plus a
// queue-based model of the FIFO, BAT flag and command status.
`timescale 1ns/1ps
module tb_ps2_kbd_host;

  logic       clk6x = 1'b0;
  logic       resetn = 1'b0;
  logic       ck1us = 1'b0;
  logic [7:0] kbd_rdata_o;
  logic       kbd_rvalid_o;
  logic [3:0] kbd_rcount_o;
  logic       kbd_rdeq_i = 1'b0;
  logic [7:0] kbd_stat_o;
  logic       kbd_bat_ok_o;
  logic [7:0] kbd_wcmddata_i = 8'h00;
  logic       kbd_enq_cmd1_i = 1'b0;
  logic       kbd_enq_cmd2_i = 1'b0;
  logic       PS2K_CLKDR, PS2K_DATADR;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       pin_clk, pin_dat;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int half_cyc = 66;

  logic [7:0] q[$];
  logic       m_bat = 1'b0;
  logic [7:0] m_stat = 8'h00;
  logic       m_two = 1'b0;

  // Wired-AND open-drain pins with pull-ups
  assign pin_clk = dev_clk & ~PS2K_CLKDR;
  assign pin_dat = dev_dat & ~PS2K_DATADR;

  ps2_kbd_host #(.RXBUF_DEPTH_BITS(3)) dut (
    .clk6x(clk6x), .resetn(resetn), .ck1us(ck1us),
    .kbd_rdata_o(kbd_rdata_o), .kbd_rvalid_o(kbd_rvalid_o),
    .kbd_rcount_o(kbd_rcount_o), .kbd_rdeq_i(kbd_rdeq_i),
    .kbd_stat_o(kbd_stat_o), .kbd_bat_ok_o(kbd_bat_ok_o),
    .kbd_wcmddata_i(kbd_wcmddata_i), .kbd_enq_cmd1_i(kbd_enq_cmd1_i),
    .kbd_enq_cmd2_i(kbd_enq_cmd2_i),
    .PS2K_CLK(pin_clk), .PS2K_DATA(pin_dat),
    .PS2K_CLKDR(PS2K_CLKDR), .PS2K_DATADR(PS2K_DATADR)
  );

  always #10 clk6x = ~clk6x;

  // One microsecond is two clk6x cycles here to keep the long timeouts short
  initial begin
    forever begin
      @(negedge clk6x);
      ck1us = ~ck1us;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk6x);
  endtask

  task automatic chk_fifo(input string tag);
    logic [7:0] head;
    head = (q.size() != 0) ? q[0] : 8'h00;
    chk({tag, ".rcount"}, 32'(kbd_rcount_o), 32'(q.size()));
    chk({tag, ".rvalid"}, 32'(kbd_rvalid_o), 32'(q.size() != 0));
    chk({tag, ".rdata"}, 32'(kbd_rdata_o), 32'(head));
    chk({tag, ".bat_ok"}, 32'(kbd_bat_ok_o), 32'(m_bat));
  endtask

  // Reference behaviour for one device-to-host byte
  task automatic model_rx(input logic [7:0] b, input bit bad);
    if (!bad) begin
      if (b == 8'hAA) m_bat = 1'b1;
      if ((b == 8'hFA || b == 8'hFE) && m_stat == 8'h01) begin
        if (b == 8'hFE) begin
          m_stat = 8'hFE;
          m_two  = 1'b0;
        end else if (m_two) begin
          m_two = 1'b0;
        end else begin
          m_stat = 8'hFA;
        end
      end else if (q.size() < 8) begin
        q.push_back(b);
      end
    end
  endtask

  // Device-to-host frame; bad=1 corrupts the parity bit
  task automatic dev_send(input logic [7:0] b, input bit bad);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      dev_dat = fr[i];
      wait_cyc(half_cyc);
      dev_clk = 1'b0;
      wait_cyc(half_cyc);
      dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
    wait_cyc(half_cyc);
    model_rx(b, bad);
  endtask

  // Truncated frame: start bit plus a few data bits, then silence
  task automatic dev_partial(input int nbits);
    for (int i = 0; i < nbits; i++) begin
      dev_dat = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
      wait_cyc(half_cyc);
      dev_clk = 1'b0;
      wait_cyc(half_cyc);
      dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
  endtask

  task automatic enq(input bit two, input logic [7:0] d);
    kbd_wcmddata_i = d;
    if (two) kbd_enq_cmd2_i = 1'b1;
    else     kbd_enq_cmd1_i = 1'b1;
    wait_cyc(1);
    kbd_enq_cmd1_i = 1'b0;
    kbd_enq_cmd2_i = 1'b0;
  endtask

  task automatic pop();
    kbd_rdeq_i = 1'b1;
    wait_cyc(1);
    kbd_rdeq_i = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  // Device side of a host-to-device transfer, acknowledging with DATA low
  task automatic host_recv(input string tag, input bit chk_len, output logic [7:0] got);
    int n;
    logic [10:0] bits;
    n = 0;
    while (!PS2K_CLKDR && n < 2000) begin
      wait_cyc(1);
      n++;
    end
    chk({tag, ".inhibit"}, 32'(PS2K_CLKDR), 32'd1);
    n = 0;
    while (PS2K_CLKDR && n < 1000) begin
      wait_cyc(1);
      n++;
    end
    if (chk_len) chk({tag, ".inh_len_ok"}, 32'(n >= 194 && n <= 206), 32'd1);
    chk({tag, ".rts_data"}, 32'(PS2K_DATADR), 32'd1);
    for (int k = 0; k < 11; k++) begin
      wait_cyc(half_cyc);
      bits[k] = pin_dat;
      if (k == 10) begin
        dev_dat = 1'b0;
        wait_cyc(4);
      end
      dev_clk = 1'b0;
      wait_cyc(half_cyc);
      dev_clk = 1'b1;
    end
    dev_dat = 1'b1;
    got = bits[8:1];
    chk({tag, ".start"}, 32'(bits[0]), 32'd0);
    chk({tag, ".parity_odd"}, 32'(^bits[9:1]), 32'd1);
    chk({tag, ".stop"}, 32'(bits[10]), 32'd1);
  endtask

  initial begin : main
    logic [7:0] got, b, first;
    int n;

    // Reset and idle
    wait_cyc(5);
    resetn = 1'b1;
    wait_cyc(200);
    chk("rst.rdata", 32'(kbd_rdata_o), 32'h00);
    chk("rst.rvalid", 32'(kbd_rvalid_o), 32'd0);
    chk("rst.rcount", 32'(kbd_rcount_o), 32'd0);
    chk("rst.stat", 32'(kbd_stat_o), 32'h00);
    chk("rst.clkdr", 32'(PS2K_CLKDR), 32'd0);
    chk("rst.datadr", 32'(PS2K_DATADR), 32'd0);
    chk("rst.bat", 32'(kbd_bat_ok_o), 32'd0);

    // Two received bytes at 33 us half-period, then drain plus an empty pop
    half_cyc = 66;
    dev_send(8'hC7, 1'b0);
    dev_send(8'h7C, 1'b0);
    chk_fifo("rx2");
    pop();
    chk_fifo("pop1");
    pop();
    chk_fifo("pop2");
    pop();
    chk_fifo("pop_empty");

    // One-byte command, ACKed, then reply timeout
    half_cyc = 40;
    enq(1'b0, 8'hA5);
    m_stat = 8'h01;
    m_two  = 1'b0;
    chk("cmd1.clkdr", 32'(PS2K_CLKDR), 32'd1);
    chk("cmd1.stat", 32'(kbd_stat_o), 32'(m_stat));
    host_recv("cmd1", 1'b1, got);
    chk("cmd1.byte", 32'(got), 32'hA5);
    wait_cyc(39600);
    chk("cmd1.stat_wait", 32'(kbd_stat_o), 32'(m_stat));
    n = 0;
    while (kbd_stat_o == 8'h01 && n < 2000) begin
      wait_cyc(1);
      n++;
    end
    m_stat = 8'hFE;
    chk("cmd1.stat_tmo", 32'(kbd_stat_o), 32'(m_stat));

    // Two-byte command: first pulse only loads, a cmd1 during INHIBIT is ignored
    enq(1'b1, 8'h55);
    wait_cyc(5);
    chk("cmd2.wait_clkdr", 32'(PS2K_CLKDR), 32'd0);
    enq(1'b1, 8'hAA);
    m_stat = 8'h01;
    m_two  = 1'b1;
    wait_cyc(20);
    enq(1'b0, 8'h00);
    host_recv("cmd2a", 1'b0, got);
    chk("cmd2a.byte", 32'(got), 32'h55);
    dev_send(8'hFA, 1'b0);
    host_recv("cmd2b", 1'b0, got);
    chk("cmd2b.byte", 32'(got), 32'hAA);
    chk("cmd2b.stat", 32'(kbd_stat_o), 32'(m_stat));
    dev_send(8'hFA, 1'b0);
    chk("cmd2.stat", 32'(kbd_stat_o), 32'(m_stat));
    chk_fifo("cmd2");

    // Corrupt parity is dropped; BAT code sets the flag and is queued
    b = 8'($urandom_range(0, 255));
    dev_send(b, 1'b1);
    chk_fifo("badpar");
    dev_send(8'hAA, 1'b0);
    chk_fifo("bat");

    // Stalled frame is abandoned after the mid-frame timeout
    dev_partial(4);
    wait_cyc(4200);
    chk_fifo("partial");
    b = 8'($urandom_range(0, 255));
    dev_send(b, 1'b0);
    chk_fifo("after_tmo");

    // Command rejected by the device
    b = 8'($urandom_range(0, 255));
    enq(1'b0, b);
    m_stat = 8'h01;
    m_two  = 1'b0;
    host_recv("cmdfe", 1'b1, got);
    chk("cmdfe.byte", 32'(got), 32'(b));
    dev_send(8'hFE, 1'b0);
    chk("cmdfe.stat", 32'(kbd_stat_o), 32'(m_stat));
    chk_fifo("cmdfe");

    // Drain, then overflow with random bytes and drain again in order
    while (q.size() != 0) pop();
    chk_fifo("drained");
    first = 8'h00;
    for (int i = 0; i < 9; i++) begin
      b = 8'($urandom_range(0, 255));
      if (i == 0) first = b;
      dev_send(b, 1'b0);
    end
    chk("full.rcount", 32'(kbd_rcount_o), 32'd8);
    chk("full.head", 32'(kbd_rdata_o), 32'(first));
    chk_fifo("full");
    for (int i = 0; i < 8; i++) begin
      pop();
      chk_fifo($sformatf("drain%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
